serial_tx: RTL
==============

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits; legal range 1..32.
REQ-002 Parameter BIT_CYCLES, default 1: clock cycles each serial bit is held; legal range 1..255.
REQ-003 Parameter PREAMBLE, default 3'b110: preamble bits, sent MSB first.
REQ-004 Port clock  input  1: single clock; all state updates on rising edge.
REQ-005 Port reset_b  input  1: asynchronous, active-low reset.
REQ-006 Port start  input  1: request to send the word on data.
REQ-007 Port data  input  DATA_W: payload; sampled only on an accept edge.
REQ-008 Port ready  output  1: high when a request can be accepted.
REQ-009 Port busy  output  1: high while a frame is being sent.
REQ-010 Port serial_out  output  1: serial line; idle level 0.
REQ-011 Port done  output  1: one-cycle pulse after the stop bit ends.

Function
REQ-012 Frame order SHALL be: 3 preamble bits, DATA_W data bits MSB first, 1 even-parity bit, 1 stop bit of value 1. Total frame: (DATA_W+5) bits.
REQ-013 Parity bit SHALL equal XOR of all data bits, so ones(data)+parity is even.
REQ-014 The FSM SHALL have exactly these states: IDLE, PRE, DATA, PARITY, STOP.
  - IDLE->PRE on accept.
  - PRE->DATA after 3 bits.
  - DATA->PARITY after DATA_W bits.
  - PARITY->STOP after 1 bit.
  - STOP->IDLE after 1 bit.
REQ-015 An accept SHALL occur on a rising edge where start=1 and ready=1; data is latched into a shift register at that edge.
REQ-016 ready SHALL be 1 only in IDLE; busy SHALL equal ~ready.
REQ-017 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-018 start held high continuously SHALL produce back-to-back frames separated by exactly one IDLE cycle.
REQ-019 After an accept at edge k, the first preamble bit SHALL appear on serial_out at edge k+1.
REQ-020 Each bit SHALL be held for exactly BIT_CYCLES cycles; a frame occupies (DATA_W+5)*BIT_CYCLES cycles.
REQ-021 serial_out SHALL be registered (no glitches) and SHALL be 0 in IDLE.
REQ-022 done SHALL be 1 for exactly the first IDLE cycle after STOP, and 0 otherwise.
REQ-023 Changes on data after accept SHALL NOT affect the frame in flight.
REQ-024 The bit counter SHALL count 0..DATA_W-1 with no wrap. The cycle counter SHALL count 0..BIT_CYCLES-1 and reload on every bit boundary.

Reset
REQ-025 reset_b=0 SHALL immediately force: state=IDLE, serial_out=0, done=0, ready=1, busy=0, counters=0, shift register=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no done pulse. The first accept after release SHALL send a complete new frame.
REQ-027 Reset release SHALL take effect on the next rising edge; an accept is possible on that edge.

Structure
REQ-028 Package serial_pkg SHALL hold:
  - the tx_state_t enum (IDLE, PRE, DATA, PARITY, STOP);
  - PREAMBLE_W=3;
  - STOP_BIT=1'b1.
REQ-029 Sub-module bit_timer (counts BIT_CYCLES, emits a bit_tick on the last cycle of each bit) SHALL be instantiated once.

Verification (clock period 10, BIT_CYCLES=1, DATA_W=8 unless stated)
REQ-030 Reset low 12 time units, then start=1 for one cycle with data=8'h07 -> serial_out = 1,1,0,0,0,0,0,0,1,1,1,1,1, then 0; done pulses once, 13 cycles after the accept edge.
REQ-031 data=8'hA5 with BIT_CYCLES=3 -> each bit held 3 cycles; parity bit 0; busy high for 39 cycles.
REQ-032 start held high, data=8'hFF then 8'h00 -> two frames with exactly one IDLE cycle (ready=1, done=1) between them; second parity bit 0.
REQ-033 start pulsed at cycle 5 of a frame with data=8'h3C -> ignored; the frame in flight is unchanged and no second frame is sent.
REQ-034 reset_b pulled low during data bit 4 -> serial_out=0 and ready=1 immediately, no done pulse; the next accept of 8'h81 sends a full, correct frame.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg
//   Shared definitions for the serial_tx framer: the transmit FSM state
//   type, the fixed preamble length and the stop-bit level.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRE    = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int   PREAMBLE_W = 3;
    localparam logic STOP_BIT   = 1'b1;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// bit_timer
//   Paces the serial line: counts clock cycles within one serial bit and
//   flags the last cycle of each bit.
//   Ports:
//     clk_i   - clock
//     rst_ni  - asynchronous active-low reset
//     en_i    - high while a frame is in flight; low holds the count at 0
//     tick_o  - high on the last cycle of every bit
module bit_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic tick_o
);

    localparam int CNT_W = 8;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == CNT_W'(BIT_CYCLES - 1));

    // The count restarts on every bit boundary, so every bit lasts exactly
    // BIT_CYCLES cycles regardless of which field it belongs to.
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (tick_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// serial_tx
//   Frames a DATA_W-bit word and shifts it out serially:
//   preamble (MSB first), data (MSB first), even parity, stop bit.
//   Ports:
//     clock      - clock, rising edge active
//     reset_b    - asynchronous active-low reset
//     start      - send request; accepted when ready is high
//     data       - payload, captured on the accept edge only
//     ready      - high in IDLE, a request can be accepted
//     busy       - high while a frame is in flight (inverse of ready)
//     serial_out - registered serial line, 0 when idle
//     done       - one-cycle pulse in the first IDLE cycle after a frame
//
//   state  | meaning
//   IDLE   | line at 0, waiting for start
//   PRE    | sending the preamble bits
//   DATA   | sending the payload bits, MSB first
//   PARITY | sending the even-parity bit
//   STOP   | sending the stop bit
module serial_tx
    import serial_pkg::*;
#(
    parameter int                    DATA_W     = 8,
    parameter int                    BIT_CYCLES = 1,
    parameter logic [PREAMBLE_W-1:0] PREAMBLE   = 3'b110
) (
    input  logic              clock,
    input  logic              reset_b,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              busy,
    output logic              serial_out,
    output logic              done
);

    localparam int CNT_W = 6;

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              sout_q, sout_d;
    logic              done_q, done_d;
    logic              bit_tick;
    logic              accept;

    assign ready      = (state_q == IDLE);
    assign busy       = ~ready;
    assign accept     = start & ready;
    assign serial_out = sout_q;
    assign done       = done_q;

    bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clk_i (clock),
        .rst_ni(reset_b),
        .en_i  (busy),
        .tick_o(bit_tick)
    );

    // sout_d is the line value for the bit that starts at the coming edge,
    // so serial_out changes on the same edge as the state it belongs to.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        par_d     = par_q;
        bit_cnt_d = bit_cnt_q;
        sout_d    = sout_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                sout_d = 1'b0;
                if (accept) begin
                    state_d   = PRE;
                    shift_d   = data;
                    par_d     = ^data;
                    bit_cnt_d = '0;
                    sout_d    = PREAMBLE[PREAMBLE_W-1];
                end
            end
            PRE: begin
                if (bit_tick) begin
                    if (bit_cnt_q == CNT_W'(PREAMBLE_W - 1)) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        sout_d    = shift_q[DATA_W-1];
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        sout_d    = (bit_cnt_q == '0) ? PREAMBLE[PREAMBLE_W-2]
                                                      : PREAMBLE[PREAMBLE_W-3];
                    end
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d   = PARITY;
                        bit_cnt_d = '0;
                        sout_d    = par_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = shift_q << 1;
                        sout_d    = shift_d[DATA_W-1];
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                    sout_d  = STOP_BIT;
                end
            end
            STOP: begin
                if (bit_tick) begin
                    state_d = IDLE;
                    sout_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                sout_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            par_q     <= 1'b0;
            bit_cnt_q <= '0;
            sout_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            bit_cnt_q <= bit_cnt_d;
            sout_q    <= sout_d;
            done_q    <= done_d;
        end
    end

endmodule
